// File: rtl/ir_nec_tx.sv
// NEC infrared transmitter: a small command FIFO feeding a segment-timed FSM
// that emits NEC frames or repeat codes, with optional carrier on the marks.
module ir_nec_tx #(
  parameter int TICK_DIV_W = 16,
  parameter int CAR_DIV_W  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_EXT   = 0,
  parameter int CARRIER_EN = 1
) (
  input  logic                             mclk,
  input  logic                             reset_n,
  input  logic                             cfg_enable,
  input  logic                             cfg_polarity,
  input  logic [TICK_DIV_W-1:0]            cfg_tick_div,
  input  logic [CAR_DIV_W-1:0]             cfg_carrier_div,
  input  logic [15:0]                      cfg_gap,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic                             cmd_repeat,
  input  logic [15:0]                      cmd_addr,
  input  logic [7:0]                       cmd_data,
  output logic                             ir_signal,
  output logic                             busy,
  output logic                             frame_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level
);

  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic        rep;
    logic [15:0] addr;
    logic [7:0]  data;
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP
  } state_t;

  function automatic logic is_mark(input state_t s);
    return (s == LEAD_MARK) || (s == BIT_MARK) || (s == STOP_MARK);
  endfunction

  cmd_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level;
  logic             push, pop;
  cmd_t             head;
  logic [31:0]      frame_word;

  state_t                state, state_n;
  logic [TICK_DIV_W-1:0] tick_cnt, tdiv_q;
  logic [CAR_DIV_W-1:0]  car_cnt, cdiv_q;
  logic [15:0]           seg_left, seg_len, gap_q;
  logic [4:0]            bit_idx;
  logic [31:0]           shreg;
  logic                  rep_q, car_q, mark_q;
  logic                  load, tick_end, seg_end, mark_on;

  assign cmd_ready  = (level != LVL_W'(FIFO_DEPTH));
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state == IDLE) && (level != '0) && cfg_enable;
  assign head       = mem[rd_ptr];
  assign fifo_level = level;
  assign busy       = (state != IDLE) || (level != '0);

  // Bits go out LSB first, so word bit i is the i-th transmitted bit.
  always_comb begin
    if (ADDR_EXT != 0) frame_word = {~head.data, head.data, head.addr};
    else               frame_word = {~head.data, head.data, ~head.addr[7:0], head.addr[7:0]};
  end

  // NOTE: the FIFO storage has no reset; the pointers and level define which
  // entries are valid, so clearing the array would only cost reset fan-out.
  always_ff @(posedge mclk) begin
    if (push) mem[wr_ptr] <= '{rep: cmd_repeat, addr: cmd_addr, data: cmd_data};
  end

  assign tick_end = (tick_cnt == tdiv_q);
  assign seg_end  = (state != IDLE) && tick_end && (seg_left == '0);

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_n = state;
    seg_len = '0;
    load    = 1'b0;
    case (state)
      IDLE:
        if (pop) begin
          state_n = LEAD_MARK; seg_len = 16'd15; load = 1'b1;
        end
      LEAD_MARK:
        if (seg_end) begin
          state_n = LEAD_SPACE; seg_len = rep_q ? 16'd3 : 16'd7; load = 1'b1;
        end
      LEAD_SPACE:
        if (seg_end) begin
          state_n = rep_q ? STOP_MARK : BIT_MARK; load = 1'b1;
        end
      BIT_MARK:
        if (seg_end) begin
          state_n = BIT_SPACE; seg_len = shreg[0] ? 16'd2 : 16'd0; load = 1'b1;
        end
      BIT_SPACE:
        if (seg_end) begin
          state_n = (bit_idx == 5'd31) ? STOP_MARK : BIT_MARK; load = 1'b1;
        end
      STOP_MARK:
        if (seg_end) begin
          if (gap_q == '0) begin
            state_n = IDLE;
          end else begin
            state_n = GAP; seg_len = gap_q - 16'd1; load = 1'b1;
          end
        end
      GAP:
        if (seg_end) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge mclk) begin
    if (!reset_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      tick_cnt   <= '0;
      seg_left   <= '0;
      car_cnt    <= '0;
      car_q      <= 1'b1;
      mark_q     <= 1'b0;
      bit_idx    <= '0;
      shreg      <= '0;
      rep_q      <= 1'b0;
      tdiv_q     <= '0;
      cdiv_q     <= '0;
      gap_q      <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      mark_q     <= is_mark(state_n);
      frame_done <= (state != IDLE) && (state_n == IDLE);

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase

      // Timing configuration is frozen for the whole frame at pop.
      if (pop) begin
        tdiv_q  <= cfg_tick_div;
        cdiv_q  <= cfg_carrier_div;
        gap_q   <= cfg_gap;
        rep_q   <= head.rep;
        shreg   <= frame_word;
        bit_idx <= '0;
      end else if (state == BIT_SPACE && seg_end) begin
        shreg   <= shreg >> 1;
        bit_idx <= bit_idx + 1'b1;
      end

      if (load) begin
        tick_cnt <= '0;
        seg_left <= seg_len;
      end else if (state != IDLE) begin
        if (tick_end) begin
          tick_cnt <= '0;
          seg_left <= seg_left - 16'd1;
        end else begin
          tick_cnt <= tick_cnt + 1'b1;
        end
      end

      // Carrier phase restarts high at each mark and rests high in spaces.
      if (load || !is_mark(state_n)) begin
        car_cnt <= '0;
        car_q   <= 1'b1;
      end else if (car_cnt == cdiv_q) begin
        car_cnt <= '0;
        car_q   <= ~car_q;
      end else begin
        car_cnt <= car_cnt + 1'b1;
      end
    end
  end

  assign mark_on   = mark_q && ((CARRIER_EN != 0) ? car_q : 1'b1);
  assign ir_signal = mark_on ? cfg_polarity : ~cfg_polarity;

endmodule

// File: tb/tb_ir_nec_tx.sv
// Self-checking bench for ir_nec_tx: decodes ir_signal run lengths into frames
// and compares them against a queue of expected frames built at push time.
module tb_ir_nec_tx;

  localparam int TW    = 16;
  localparam int CW    = 8;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);

  typedef struct packed {
    logic        rep;
    logic [31:0] word;
  } exp_t;

  logic          mclk = 1'b0;
  logic          reset_n;
  logic          cfg_enable, cfg_polarity;
  logic [TW-1:0] cfg_tick_div;
  logic [CW-1:0] cfg_carrier_div;
  logic [15:0]   cfg_gap;
  logic          cmd_repeat;
  logic [15:0]   cmd_addr;
  logic [7:0]    cmd_data;
  logic [2:0]    valid, ready, ir, busy, fd;
  logic [LW-1:0] lvl [3];

  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;
  int   fd_cnt [3] = '{0, 0, 0};
  exp_t sb [$];

  logic [15:0] t4_addr [4] = '{16'hAB12, 16'h00FF, 16'h8001, 16'h5A5A};
  logic [7:0]  t4_data [4] = '{8'h00, 8'hFF, 8'h3C, 8'h81};

  always #5 mclk = ~mclk;

  always @(posedge mclk) begin
    for (int i = 0; i < 3; i++) if (fd[i]) fd_cnt[i]++;
  end

  ir_nec_tx #(.TICK_DIV_W(TW), .CAR_DIV_W(CW), .FIFO_DEPTH(DEPTH), .ADDR_EXT(0), .CARRIER_EN(0)) u_plain (
    .mclk(mclk), .reset_n(reset_n), .cfg_enable(cfg_enable), .cfg_polarity(cfg_polarity),
    .cfg_tick_div(cfg_tick_div), .cfg_carrier_div(cfg_carrier_div), .cfg_gap(cfg_gap),
    .cmd_valid(valid[0]), .cmd_ready(ready[0]), .cmd_repeat(cmd_repeat), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .ir_signal(ir[0]), .busy(busy[0]), .frame_done(fd[0]), .fifo_level(lvl[0]));

  ir_nec_tx #(.TICK_DIV_W(TW), .CAR_DIV_W(CW), .FIFO_DEPTH(DEPTH), .ADDR_EXT(0), .CARRIER_EN(1)) u_car (
    .mclk(mclk), .reset_n(reset_n), .cfg_enable(cfg_enable), .cfg_polarity(cfg_polarity),
    .cfg_tick_div(cfg_tick_div), .cfg_carrier_div(cfg_carrier_div), .cfg_gap(cfg_gap),
    .cmd_valid(valid[1]), .cmd_ready(ready[1]), .cmd_repeat(cmd_repeat), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .ir_signal(ir[1]), .busy(busy[1]), .frame_done(fd[1]), .fifo_level(lvl[1]));

  ir_nec_tx #(.TICK_DIV_W(TW), .CAR_DIV_W(CW), .FIFO_DEPTH(DEPTH), .ADDR_EXT(1), .CARRIER_EN(0)) u_ext (
    .mclk(mclk), .reset_n(reset_n), .cfg_enable(cfg_enable), .cfg_polarity(cfg_polarity),
    .cfg_tick_div(cfg_tick_div), .cfg_carrier_div(cfg_carrier_div), .cfg_gap(cfg_gap),
    .cmd_valid(valid[2]), .cmd_ready(ready[2]), .cmd_repeat(cmd_repeat), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .ir_signal(ir[2]), .busy(busy[2]), .frame_done(fd[2]), .fifo_level(lvl[2]));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input bit ext, input logic [15:0] a, input logic [7:0] d);
    if (ext) return {~d, d, a};
    return {~d, d, ~a[7:0], a[7:0]};
  endfunction

  task automatic expect_frame(input bit ext, input logic rep, input logic [15:0] a, input logic [7:0] d);
    exp_t e;
    e.rep  = rep;
    e.word = rep ? 32'h0 : exp_word(ext, a, d);
    sb.push_back(e);
  endtask

  task automatic compare_next(input string tag, input logic rep, input logic [31:0] w);
    exp_t e;
    e = 'x;
    if (sb.size() > 0) e = sb.pop_front();
    check(tag, {31'h0, rep, w}, {31'h0, e.rep, e.word});
  endtask

  // Drive one command for a single edge; starts and ends on a falling edge.
  task automatic push(input int sel, input logic rep, input logic [15:0] a, input logic [7:0] d);
    cmd_repeat  = rep;
    cmd_addr    = a;
    cmd_data    = d;
    valid[sel]  = 1'b1;
    @(negedge mclk);
    valid[sel]  = 1'b0;
  endtask

  task automatic count_run(input int sel, input logic lv, input int limit, output int n);
    n = 0;
    while (ir[sel] === lv && n < limit) begin
      n++;
      @(negedge mclk);
    end
  endtask

  // Decode one frame; d is cycles per tick. Ends on the first idle sample after the stop mark.
  task automatic recv_frame(input int sel, input int d, output int pre_idle, output int total,
                            output int bad, output logic rep, output logic [31:0] word);
    int   n;
    logic act;
    act = cfg_polarity; bad = 0; total = 0; rep = 1'b0; word = '0;
    count_run(sel, ~act, 20000, pre_idle);
    if (pre_idle >= 20000) begin bad++; return; end
    count_run(sel, act, 5000, n); total += n;
    if (n != 16 * d) begin bad++; return; end
    count_run(sel, ~act, 5000, n); total += n;
    if (n == 4 * d) begin
      rep = 1'b1;
    end else begin
      if (n != 8 * d) begin bad++; return; end
      for (int b = 0; b < 32; b++) begin
        count_run(sel, act, 5000, n); total += n;
        if (n != d) begin bad++; return; end
        count_run(sel, ~act, 5000, n); total += n;
        if (n == 3 * d) word[b] = 1'b1;
        else if (n != d) begin bad++; return; end
      end
    end
    count_run(sel, act, 5000, n); total += n;
    if (n != d) bad++;
  endtask

  initial begin
    int          pre, tot, bad, base, mk_err, sp_err;
    logic        rep;
    logic [31:0] w;

    reset_n = 1'b0; cfg_enable = 1'b1; cfg_polarity = 1'b1; cfg_tick_div = 16'd9;
    cfg_carrier_div = 8'd1; cfg_gap = 16'd0; cmd_repeat = 1'b0; cmd_addr = '0;
    cmd_data = '0; valid = '0;
    repeat (3) @(negedge mclk);
    check("rst_ir_idle", {61'h0, ir}, 64'h0);
    check("rst_busy", {61'h0, busy}, 64'h0);
    check("rst_level", lvl[0], 0);
    check("rst_ready", {61'h0, ready}, 64'h7);
    check("rst_done", {61'h0, fd}, 64'h0);
    reset_n = 1'b1;
    @(negedge mclk);

    // Plain frame, tick = 10 cycles, no gap.
    expect_frame(0, 1'b0, 16'h0000, 8'hA5);
    push(0, 1'b0, 16'h0000, 8'hA5);
    check("t1_level_after_push", lvl[0], 1);
    check("t1_busy_after_push", busy[0], 1);
    check("t1_idle_before_pop", ir[0], 0);
    recv_frame(0, 10, pre, tot, bad, rep, w);
    check("t1_pop_latency", pre, 1);
    check("t1_segments", bad, 0);
    check("t1_length", tot, 1210);
    compare_next("t1_frame", rep, w);
    check("t1_done_pulse", fd[0], 1);
    @(negedge mclk);
    check("t1_done_width", fd[0], 0);
    check("t1_done_count", fd_cnt[0], 1);

    // Repeat code.
    expect_frame(0, 1'b1, 16'h0000, 8'h00);
    push(0, 1'b1, 16'hFFFF, 8'hFF);
    recv_frame(0, 10, pre, tot, bad, rep, w);
    check("t2_segments", bad, 0);
    check("t2_length", tot, 210);
    compare_next("t2_frame", rep, w);
    @(negedge mclk);
    check("t2_done_count", fd_cnt[0], 2);

    // Carrier on marks, active-low output.
    cfg_polarity = 1'b0;
    @(negedge mclk);
    push(1, 1'b1, 16'h0000, 8'h00);
    @(negedge mclk);
    check("t3_start_low", ir[1], 0);
    mk_err = 0; sp_err = 0;
    for (int i = 0; i < 220; i++) begin
      bit   in_mark;
      int   j;
      logic expv;
      in_mark = (i < 160) || (i >= 200 && i < 210);
      j       = (i < 160) ? i : i - 200;
      expv    = (in_mark && ((j / 2) % 2 == 0)) ? cfg_polarity : ~cfg_polarity;
      if (ir[1] !== expv) begin
        if (in_mark) mk_err++;
        else         sp_err++;
      end
      @(negedge mclk);
    end
    check("t3_mark_carrier_errs", mk_err, 0);
    check("t3_space_level_errs", sp_err, 0);
    check("t3_busy_end", busy[1], 0);
    cfg_polarity = 1'b1;
    @(negedge mclk);

    // Fill FIFO while disabled, then drain with 10-tick gaps (tick = 4 cycles).
    cfg_tick_div = 16'd3; cfg_gap = 16'd10; cfg_enable = 1'b0;
    @(negedge mclk);
    for (int k = 0; k < 4; k++) begin
      expect_frame(0, 1'b0, t4_addr[k], t4_data[k]);
      push(0, 1'b0, t4_addr[k], t4_data[k]);
    end
    check("t4_ready_full", ready[0], 0);
    check("t4_level_full", lvl[0], 4);
    push(0, 1'b0, 16'hDEAD, 8'hBE);
    check("t4_level_after_reject", lvl[0], 4);
    base = fd_cnt[0];
    cfg_enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      recv_frame(0, 4, pre, tot, bad, rep, w);
      check(k == 0 ? "t4_first_latency" : "t4_gap_idle", pre, k == 0 ? 1 : 41);
      check("t4_segments", bad, 0);
      compare_next("t4_frame", rep, w);
    end
    repeat (45) @(negedge mclk);
    check("t4_busy_end", busy[0], 0);
    check("t4_level_end", lvl[0], 0);
    check("t4_done_count", fd_cnt[0] - base, 4);
    cfg_gap = 16'd0;

    // Reset during the first bit space with one command still queued.
    push(0, 1'b0, 16'h00FF, 8'h00);
    push(0, 1'b0, 16'h0001, 8'h02);
    repeat (103) @(negedge mclk);
    check("t5_in_space", ir[0], 0);
    check("t5_level_before", lvl[0], 1);
    check("t5_busy_before", busy[0], 1);
    reset_n = 1'b0;
    @(negedge mclk);
    reset_n = 1'b1;
    check("t5_ir_idle", ir[0], 0);
    check("t5_level", lvl[0], 0);
    check("t5_busy", busy[0], 0);
    check("t5_ready", ready[0], 1);
    base = fd_cnt[0];
    repeat (30) @(negedge mclk);
    check("t5_no_done", fd_cnt[0] - base, 0);
    check("t5_stays_idle", ir[0], 0);

    // Extended 16-bit address.
    expect_frame(1, 1'b0, 16'h1234, 8'h01);
    push(2, 1'b0, 16'h1234, 8'h01);
    recv_frame(2, 4, pre, tot, bad, rep, w);
    check("t6_pop_latency", pre, 1);
    check("t6_segments", bad, 0);
    compare_next("t6_frame", rep, w);
    check("t6_scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ir_nec_tx.md
Name: ir_nec_tx

Overview:
Synthesizable, parametrised NEC infrared transmitter. It buffers commands in a small FIFO and serialises them as NEC frames or NEC repeat codes, with programmable tick period, polarity, inter-frame gap and optional carrier modulation. It sits behind the peripheral register block, and its output drives the IR LED pad.

Parameters:
TICK_DIV_W, 16, width of cfg_tick_div.
CAR_DIV_W, 8, width of cfg_carrier_div.
FIFO_DEPTH, 4, command FIFO depth; must be a power of 2 and at least 2.
ADDR_EXT, 0, address mode. 0 = 8-bit address followed by its complement. 1 = 16-bit extended address with no complement.
CARRIER_EN, 1, 1 = marks are modulated by the carrier; 0 = marks are a steady active level.

Ports:
mclk  in  1  clock
reset_n  in  1  synchronous reset, active-low
cfg_enable  in  1  allows FIFO pops and frame starts
cfg_polarity  in  1  active (mark) level of ir_signal
cfg_tick_div  in  TICK_DIV_W  one tick = cfg_tick_div+1 mclk cycles
cfg_carrier_div  in  CAR_DIV_W  carrier half-period = cfg_carrier_div+1 mclk cycles
cfg_gap  in  16  idle ticks inserted after each frame
cmd_valid  in  1  command push request
cmd_ready  out  1  FIFO not full
cmd_repeat  in  1  1 = send a repeat code; address and data are ignored
cmd_addr  in  16  address; bits 15:8 are used only when ADDR_EXT=1
cmd_data  in  8  command byte
ir_signal  out  1  IR output
busy  out  1  FSM not in IDLE, or FIFO not empty
frame_done  out  1  one-cycle pulse when a frame, including its gap, completes
fifo_level  out  $clog2(FIFO_DEPTH+1)  number of buffered commands

Behaviour:
- Reset (synchronous, reset_n=0 at a mclk edge):
  - FSM goes to IDLE; FIFO empties; tick, carrier and bit counters clear.
  - Outputs: mark_q=0, frame_done=0, busy=0, fifo_level=0, cmd_ready=1.
  - The same applies when reset arrives mid-frame; the frame in progress is abandoned.
- ir_signal = mark_on ? cfg_polarity : ~cfg_polarity.
  - mark_on = mark_q & (CARRIER_EN ? car_q : 1).
  - The output is therefore the idle level (~cfg_polarity) whenever mark_q=0, including immediately after reset.
- Push: a command is written when cmd_valid & cmd_ready at an edge. Pushes while full are impossible because cmd_ready=0.
- Pop and frame start:
  - In IDLE with the FIFO non-empty and cfg_enable=1, the FSM pops at an edge and enters LEAD_MARK at that edge.
  - Latency: with an empty, idle block, a push at edge N gives a pop at edge N+1, and ir_signal goes active after edge N+1.
  - cfg_tick_div, cfg_carrier_div and cfg_gap are latched at pop.
  - The tick counter restarts at pop, so each segment lasts exactly k*(cfg_tick_div+1) cycles.
- Segment lengths, in ticks:
  - Frame: LEAD_MARK 16, LEAD_SPACE 8, then 32 bits.
  - Bit: BIT_MARK 1, then BIT_SPACE 3 for a '1' or 1 for a '0'.
  - STOP_MARK 1, then GAP for cfg_gap ticks.
  - Repeat code: LEAD_MARK 16, LEAD_SPACE 4, STOP_MARK 1, GAP.
- Bit order is LSB first.
  - ADDR_EXT=0: addr[7:0], ~addr[7:0], data, ~data.
  - ADDR_EXT=1: addr[15:0], data, ~data.
- Carrier:
  - car_q is set to 1 at the start of every mark segment.
  - car_q toggles every cfg_carrier_div+1 cycles during the mark and is held at 1 during spaces.
- Gap and completion:
  - With cfg_gap=0, GAP is skipped and STOP_MARK returns directly to IDLE.
  - frame_done pulses on the cycle after the FSM re-enters IDLE.
  - Back-to-back frames: the next pop may occur in the same cycle frame_done is high.
- cfg_enable deasserted mid-frame: the current frame and its gap complete, then no further pops occur.
- cfg_polarity must only be changed while busy=0; the output follows it live.

Test Plan:
1. polarity=1, tick_div=9, CARRIER_EN=0, gap=0, addr 0x00, data 0xA5 -> 160 cycles high, then 80 low; data bit0 space = 30 cycles low; stop mark ends 1210 cycles after the first high; one frame_done pulse.
2. cmd_repeat=1, tick_div=9 -> 160 cycles high, 40 low, 10 high, then idle; total 210 cycles.
3. CARRIER_EN=1, carrier_div=1, polarity=0 -> during each mark ir_signal shows 2 cycles low, 2 cycles high repeating, starting low; constant high during spaces.
4. cfg_enable=0, push 5 commands -> cmd_ready drops after the 4th, fifo_level=4, 5th is not accepted. Then set enable=1, gap=10 -> 4 frames separated by 10-tick idle gaps, 4 frame_done pulses, busy ends at 0.
5. reset_n=0 for one edge during BIT_SPACE -> after that edge ir_signal=~polarity, fifo_level=0, busy=0; no frame_done pulse.
6. ADDR_EXT=1, addr 0x1234, data 0x01 -> decoded bitstream is 0x34, 0x12, 0x01, 0xFE, each LSB first.
